// File: rtl/hpdcache_memarray_banked_if.sv
// rtl/hpdcache_memarray_banked_if.sv - request/response/init port bundle of the banked memory array
interface hpdcache_memarray_banked_if #(
  parameter int WAYS    = 4,
  parameter int SETS    = 64,
  parameter int ENTRY_W = 32
);
  localparam int SET_W = $clog2(SETS);

  logic                      init_i;
  logic                      init_busy_o;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [WAYS-1:0]           req_way_i;
  logic [SET_W-1:0]          req_set_i;
  logic [WAYS*ENTRY_W-1:0]   req_wdata_i;
  logic [WAYS*ENTRY_W/8-1:0] req_be_i;
  logic                      rsp_valid_o;
  logic [WAYS*ENTRY_W-1:0]   rsp_rdata_o;

  modport master (
    output init_i, req_valid_i, req_we_i, req_way_i, req_set_i, req_wdata_i, req_be_i,
    input  init_busy_o, req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  init_i, req_valid_i, req_we_i, req_way_i, req_set_i, req_wdata_i, req_be_i,
    output init_busy_o, req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/hpdcache_memarray_banked.sv
// rtl/hpdcache_memarray_banked.sv - multi-way SRAM array with init sweep, byte-masked writes and pipelined reads
module hpdcache_memarray_banked #(
  parameter int                 WAYS     = 4,
  parameter int                 SETS     = 64,
  parameter int                 ENTRY_W  = 32,
  parameter int                 RD_PIPE  = 0,
  parameter logic [ENTRY_W-1:0] INIT_VAL = '0
) (
  input logic                       clk_i,
  input logic                       rst_i,
  hpdcache_memarray_banked_if.slave io
);
  localparam int SET_W = $clog2(SETS);
  localparam int BE_W  = ENTRY_W / 8;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

  state_t                  r_state;
  logic [SET_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_ready;
  logic [ENTRY_W-1:0]      r_mem [WAYS][SETS];
  logic                    r_v1;
  logic [WAYS*ENTRY_W-1:0] r_d1;

  logic                    w_acc;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic                    w_rd_inflight;
  logic [WAYS-1:0]         w_mem_we;
  logic [SET_W-1:0]        w_mem_set;
  logic [WAYS*ENTRY_W-1:0] w_mem_wdata;
  logic [WAYS*BE_W-1:0]    w_mem_be;
  logic [WAYS*ENTRY_W-1:0] w_rd_data;

  assign w_acc    = io.req_valid_i & r_ready;
  assign w_rd_acc = w_acc & ~io.req_we_i;
  assign w_wr_acc = w_acc & io.req_we_i;

  assign io.init_busy_o = r_busy;
  assign io.req_ready_o = r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SET_W'(SETS - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (io.init_i) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!w_rd_inflight) r_state <= ST_INIT;
        end
        default: begin
          r_state <= ST_INIT;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // The sweep owns the write port in INIT; requests are never accepted there.
  always_comb begin
    w_mem_we    = '0;
    w_mem_set   = io.req_set_i;
    w_mem_wdata = io.req_wdata_i;
    w_mem_be    = io.req_be_i;
    if (r_state == ST_INIT) begin
      w_mem_we    = '1;
      w_mem_set   = r_cnt;
      w_mem_wdata = {WAYS{INIT_VAL}};
      w_mem_be    = '1;
    end else if (w_wr_acc) begin
      w_mem_we = io.req_way_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WAYS; w++) begin
      if (w_mem_we[w]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_mem_be[w*BE_W + b])
            r_mem[w][w_mem_set][b*8 +: 8] <= w_mem_wdata[w*ENTRY_W + b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (io.req_way_i[w]) w_rd_data[w*ENTRY_W +: ENTRY_W] = r_mem[w][io.req_set_i];
    end
  end

  // Data registers load only on a response so the output holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) r_d1 <= w_rd_data;
    end
  end

  if (RD_PIPE != 0) begin : g_pipe
    logic                    r_v2;
    logic [WAYS*ENTRY_W-1:0] r_d2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign io.rsp_valid_o = r_v2;
    assign io.rsp_rdata_o = r_d2;
    assign w_rd_inflight  = r_v1 | r_v2;
  end else begin : g_nopipe
    assign io.rsp_valid_o = r_v1;
    assign io.rsp_rdata_o = r_d1;
    assign w_rd_inflight  = r_v1;
  end
endmodule
